// File: rtl/life_grid_engine_if.sv
// Host-side row port and control/status bundle for life_grid_engine.
// Latency: none, plain wires; rd_data is registered inside the engine (1 cycle).
// Backpressure: none; the host watches busy and gen_done, and writes are dropped while busy.
// Ports: master = host (drives writes, reads and controls), slave = engine (drives status).
interface life_grid_engine_if #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int GEN_W  = 16,
   parameter int PACE_W = 24
);
   localparam int ROW_W = $clog2(HEIGHT);

   logic              wr_en;
   logic [ROW_W-1:0]  wr_row;
   logic [WIDTH-1:0]  wr_data;
   logic [ROW_W-1:0]  rd_row;
   logic [WIDTH-1:0]  rd_data;
   logic              step;
   logic              run;
   logic              clear;
   logic [PACE_W-1:0] pace;
   logic              busy;
   logic              gen_done;
   logic              still;
   logic [GEN_W-1:0]  gen_count;

   modport master (
      output wr_en, wr_row, wr_data, rd_row, step, run, clear, pace,
      input  rd_data, busy, gen_done, still, gen_count
   );

   modport slave (
      input  wr_en, wr_row, wr_data, rd_row, step, run, clear, pace,
      output rd_data, busy, gen_done, still, gen_count
   );
endinterface

// File: rtl/life_grid_engine.sv
// Game-of-Life core: WIDTH x HEIGHT register grid, one row of the next generation per clock.
// Latency: step at edge k -> rows written k+1..k+HEIGHT, gen_done high after edge k+HEIGHT+1; rd_data 1 cycle.
// Backpressure: step ignored while busy, wr_en ignored outside IDLE; clear aborts at once.
// Ports: sys_clk, Reset_n (async active-low), host (life_grid_engine_if.slave): row write/read port,
//        step/run/clear/pace controls, busy/gen_done/still/gen_count status.
// Option macro LIFE_TORUS_EN: when defined the grid edges wrap; otherwise cells outside the grid are dead.
module life_grid_engine #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int GEN_W  = 16,
   parameter int PACE_W = 24
) (
   input  logic               sys_clk,
   input  logic               Reset_n,
   life_grid_engine_if.slave  host
);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE, WAIT} state_t;

   state_t            state_q,   state_d;
   logic [ROW_W-1:0]  row_q,     row_d;
   logic [WIDTH-1:0]  grid_q [HEIGHT];
   logic [WIDTH-1:0]  grid_d [HEIGHT];
   logic [WIDTH-1:0]  prev_q,    prev_d;     // old (pre-update) copy of row r-1
   logic [PACE_W-1:0] wait_q,    wait_d;
   logic              changed_q, changed_d;
   logic              busy_q,    busy_d;
   logic              gen_done_q, gen_done_d;
   logic              still_q,   still_d;
   logic [GEN_W-1:0]  cnt_q,     cnt_d;
   logic [WIDTH-1:0]  rd_data_q, rd_data_d;
`ifdef LIFE_TORUS_EN
   logic [WIDTH-1:0]  row0_q,    row0_d;     // old row 0, needed as the row below the last row
`endif

   logic [ROW_W-1:0]  row_nxt;
   logic [WIDTH-1:0]  cur_row, below_row, new_row, top_edge;
   logic              start;

   // Next state of one row from its old upper, own and lower rows. Rows are
   // extended by one column each side so column c sees ext[c..c+2].
   function automatic logic [WIDTH-1:0] life_row(input logic [WIDTH-1:0] up,
                                                 input logic [WIDTH-1:0] mid,
                                                 input logic [WIDTH-1:0] dn);
      logic [WIDTH+1:0] eu, em, ed;
      logic [3:0]       n;
      logic [WIDTH-1:0] res;
`ifdef LIFE_TORUS_EN
      eu = {up[0],  up,  up[WIDTH-1]};
      em = {mid[0], mid, mid[WIDTH-1]};
      ed = {dn[0],  dn,  dn[WIDTH-1]};
`else
      eu = {1'b0, up,  1'b0};
      em = {1'b0, mid, 1'b0};
      ed = {1'b0, dn,  1'b0};
`endif
      res = '0;
      for (int c = 0; c < WIDTH; c++) begin
         n = 4'(eu[c]) + 4'(eu[c+1]) + 4'(eu[c+2])
           + 4'(em[c])               + 4'(em[c+2])
           + 4'(ed[c]) + 4'(ed[c+1]) + 4'(ed[c+2]);
         res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
      end
      return res;
   endfunction

   assign row_nxt = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
   assign cur_row = grid_q[row_q];

`ifdef LIFE_TORUS_EN
   assign top_edge  = grid_q[LAST_ROW];
   assign below_row = (row_q == LAST_ROW) ? row0_q : grid_q[row_nxt];
`else
   assign top_edge  = '0;
   assign below_row = (row_q == LAST_ROW) ? '0 : grid_q[row_nxt];
`endif

   assign new_row = life_row(prev_q, cur_row, below_row);

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      grid_d     = grid_q;
      prev_d     = prev_q;
      wait_d     = wait_q;
      changed_d  = changed_q;
      gen_done_d = 1'b0;
      still_d    = still_q;
      cnt_d      = cnt_q;
      rd_data_d  = grid_q[host.rd_row];
      start      = 1'b0;
`ifdef LIFE_TORUS_EN
      row0_d     = row0_q;
`endif

      case (state_q)
         IDLE: begin
            if (host.wr_en) begin
               grid_d[host.wr_row] = host.wr_data;
               still_d             = 1'b0;
            end
            if (host.step || host.run) start = 1'b1;
         end
         COMPUTE: begin
            grid_d[row_q] = new_row;
            prev_d        = cur_row;
            changed_d     = changed_q || (new_row != cur_row);
            row_d         = row_nxt;
            if (row_q == LAST_ROW) state_d = DONE;
         end
         DONE: begin
            gen_done_d = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            still_d    = ~changed_q;
            if (!host.run) begin
               state_d = IDLE;
            end else if (host.pace == '0) begin
               start = 1'b1;
            end else begin
               state_d = WAIT;
               wait_d  = '0;
            end
         end
         WAIT: begin
            // pace+1 cycles here gives a generation period of HEIGHT+2+pace
            if (!host.run) begin
               state_d = IDLE;
            end else if (wait_q == host.pace) begin
               start = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Snapshot the neighbours of row 0 before any row of the grid changes.
      if (start) begin
         state_d   = COMPUTE;
         row_d     = '0;
         prev_d    = top_edge;
         changed_d = 1'b0;
`ifdef LIFE_TORUS_EN
         row0_d    = grid_q[0];
`endif
      end

      if (host.clear) begin
         state_d    = IDLE;
         row_d      = '0;
         changed_d  = 1'b0;
         gen_done_d = 1'b0;
         still_d    = 1'b0;
         cnt_d      = '0;
         for (int r = 0; r < HEIGHT; r++) grid_d[r] = '0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         row_q      <= '0;
         prev_q     <= '0;
         wait_q     <= '0;
         changed_q  <= 1'b0;
         busy_q     <= 1'b0;
         gen_done_q <= 1'b0;
         still_q    <= 1'b0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         for (int r = 0; r < HEIGHT; r++) grid_q[r] <= '0;
`ifdef LIFE_TORUS_EN
         row0_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         prev_q     <= prev_d;
         wait_q     <= wait_d;
         changed_q  <= changed_d;
         busy_q     <= busy_d;
         gen_done_q <= gen_done_d;
         still_q    <= still_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         grid_q     <= grid_d;
`ifdef LIFE_TORUS_EN
         row0_q     <= row0_d;
`endif
      end
   end

   assign host.rd_data   = rd_data_q;
   assign host.busy      = busy_q;
   assign host.gen_done  = gen_done_q;
   assign host.still     = still_q;
   assign host.gen_count = cnt_q;
endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: directed scenarios, a generation-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_life_grid_engine;
   localparam int W  = 16;
   localparam int H  = 16;
   localparam int GW = 4;
   localparam int PW = 24;
   localparam int RW = $clog2(H);

   logic sys_clk = 1'b0;
   logic Reset_n;
   always #5 sys_clk = ~sys_clk;

   life_grid_engine_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW), .PACE_W(PW)) hif();

   life_grid_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW), .PACE_W(PW)) dut (
      .sys_clk (sys_clk),
      .Reset_n (Reset_n),
      .host    (hif)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;
   bit sweep    = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_grid [H];
   logic [W-1:0] m_next [H];
   int           m_mode;      // 0 idle, 1 generating, 2 pacing
   int           m_cyc;
   int           m_wait;
   bit           m_same;
   logic         exp_busy, exp_gd, exp_still;
   int           exp_cnt;
   logic [W-1:0] exp_rd;

   function automatic bit cell_at(int r, int c);
`ifdef LIFE_TORUS_EN
      r = (r + H) % H;
      c = (c + W) % W;
`else
      if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
`endif
      return m_grid[r][c];
   endfunction

   task automatic begin_gen();
      int n;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) n += int'(cell_at(r + dr, c + dc));
            m_next[r][c] = (n == 3) || (m_grid[r][c] && n == 2);
         end
      m_same = 1'b1;
      for (int r = 0; r < H; r++) if (m_next[r] != m_grid[r]) m_same = 1'b0;
      m_mode = 1;
      m_cyc  = 0;
   endtask

   always @(posedge sys_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int r = 0; r < H; r++) m_grid[r] = '0;
         m_mode = 0; exp_busy = 0; exp_gd = 0; exp_still = 0; exp_cnt = 0; exp_rd = '0;
      end else begin
         exp_rd = m_grid[hif.rd_row];
         exp_gd = 1'b0;
         if (hif.clear) begin
            for (int r = 0; r < H; r++) m_grid[r] = '0;
            exp_cnt = 0; exp_still = 0; m_mode = 0;
         end else if (m_mode == 0) begin
            if (hif.wr_en) begin
               m_grid[hif.wr_row] = hif.wr_data;
               exp_still = 1'b0;
            end
            if (hif.step || hif.run) begin_gen();
         end else if (m_mode == 1) begin
            m_cyc++;
            if (m_cyc <= H) begin
               m_grid[m_cyc-1] = m_next[m_cyc-1];
            end else begin
               exp_gd    = 1'b1;
               exp_cnt   = (exp_cnt + 1) % (1 << GW);
               exp_still = m_same;
               if (!hif.run) m_mode = 0;
               else if (hif.pace == 0) begin_gen();
               else begin m_mode = 2; m_wait = 0; end
            end
         end else begin
            if (!hif.run) m_mode = 0;
            else begin
               m_wait++;
               if (m_wait == int'(hif.pace) + 1) begin_gen();
            end
         end
         exp_busy = (m_mode != 0);
      end
   end

   always @(negedge sys_clk) begin
      if (chk_en) begin
         check("busy",      32'(hif.busy),      32'(exp_busy));
         check("gen_done",  32'(hif.gen_done),  32'(exp_gd));
         check("gen_count", 32'(hif.gen_count), 32'(exp_cnt));
         check("still",     32'(hif.still),     32'(exp_still));
         check("rd_data",   32'(hif.rd_data),   32'(exp_rd));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge sys_clk);
         if (sweep) hif.rd_row = hif.rd_row + 1'b1;
      end
   endtask

   task automatic wr(input int r, input logic [W-1:0] d);
      hif.wr_en = 1'b1; hif.wr_row = RW'(r); hif.wr_data = d;
      tick(1);
      hif.wr_en = 1'b0;
   endtask

   task automatic do_clear();
      hif.clear = 1'b1; tick(1); hif.clear = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (hif.busy === 1'b1 && n < 200) begin tick(1); n++; end
      check("wait_idle_timeout", 32'(hif.busy), 32'd0);
   endtask

   task automatic do_step();
      hif.step = 1'b1; tick(1); hif.step = 1'b0;
      wait_idle();
   endtask

   task automatic read_row(input int r, input logic [W-1:0] exp, input string name);
      sweep = 1'b0;
      hif.rd_row = RW'(r);
      tick(1);
      check(name, 32'(hif.rd_data), 32'(exp));
      sweep = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int first, second, t, seen;
      hif.wr_en = 0; hif.wr_row = '0; hif.wr_data = '0; hif.rd_row = '0;
      hif.step = 0; hif.run = 0; hif.clear = 0; hif.pace = '0;
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #1;
      check("rst_busy",     32'(hif.busy),      0);
      check("rst_gen_done", 32'(hif.gen_done),  0);
      check("rst_still",    32'(hif.still),     0);
      check("rst_count",    32'(hif.gen_count), 0);
      check("rst_rd_data",  32'(hif.rd_data),   0);
      tick(2);
      Reset_n = 1'b1;
      chk_en  = 1'b1;

      // Blinker with exact gen_done timing
      wr(5, 16'h0070);
      hif.step = 1'b1; tick(1); hif.step = 1'b0;
      tick(H);
      check("blink_gd_early", 32'(hif.gen_done), 0);
      tick(1);
      check("blink_gd",       32'(hif.gen_done),  1);
      check("blink_count",    32'(hif.gen_count), 1);
      check("blink_busy",     32'(hif.busy),      0);
      read_row(3, 16'h0000, "blink_row3");
      read_row(4, 16'h0020, "blink_row4");
      read_row(5, 16'h0020, "blink_row5");
      read_row(6, 16'h0020, "blink_row6");
      read_row(7, 16'h0000, "blink_row7");

      // Block is a still life; a write clears still
      do_clear();
      wr(2, 16'h0006); wr(3, 16'h0006);
      do_step();
      check("block_still", 32'(hif.still), 1);
      read_row(2, 16'h0006, "block_row2");
      read_row(3, 16'h0006, "block_row3");
      wr(0, 16'h0000);
      check("block_wr_still", 32'(hif.still), 0);

      // Glider at bottom-right corner, four generations
      do_clear();
      wr(13, 16'h4000); wr(14, 16'h8000); wr(15, 16'hE000);
      repeat (4) do_step();
`ifdef LIFE_TORUS_EN
      read_row(14, 16'h8000, "glider_row14");
      read_row(15, 16'h0001, "glider_row15");
      read_row(0,  16'hC001, "glider_row0");
`else
      read_row(14, 16'hC000, "glider_row14");
      read_row(15, 16'hC000, "glider_row15");
      read_row(0,  16'h0000, "glider_row0");
`endif

      // Paced run: period HEIGHT+2+pace, then drop run while pacing
      do_clear();
      wr(5, 16'h0070);
      hif.pace = PW'(10); hif.run = 1'b1;
      first = -1; second = -1; t = 0;
      while (second < 0 && t < 300) begin
         tick(1); t++;
         if (hif.gen_done === 1'b1) begin
            if (first < 0) first = t; else second = t;
         end
      end
      check("run_period", 32'(second - first), 32'(H + 12));
      tick(3);
      hif.run = 1'b0;
      tick(1);
      check("run_stop_busy", 32'(hif.busy), 0);
      hif.pace = '0;

      // Clear during COMPUTE row 7
      wr(5, 16'h0070);
      hif.step = 1'b1; tick(1); hif.step = 1'b0;
      tick(7);
      hif.clear = 1'b1; tick(1); hif.clear = 1'b0;
      check("clr_busy",  32'(hif.busy),      0);
      check("clr_count", 32'(hif.gen_count), 0);
      seen = 0;
      for (int i = 0; i < H + 3; i++) begin tick(1); if (hif.gen_done === 1'b1) seen++; end
      check("clr_no_gd", 32'(seen), 0);
      read_row(5, 16'h0000, "clr_row5");
      read_row(0, 16'h0000, "clr_row0");

      // Write while busy is dropped
      wr(5, 16'h0070);
      hif.step = 1'b1; tick(1); hif.step = 1'b0;
      tick(2);
      wr(9, 16'hFFFF);
      wait_idle();
      read_row(9, 16'h0000, "busy_wr_row9");
      read_row(5, 16'h0020, "busy_wr_row5");

      // Counter wrap with GEN_W=4 on an empty grid
      do_clear();
      repeat (16) do_step();
      check("wrap_count", 32'(hif.gen_count), 0);
      check("wrap_still", 32'(hif.still),     1);

      // Asynchronous reset in the middle of a free run
      wr(5, 16'h0070);
      hif.run = 1'b1;
      tick(40);
      #2 Reset_n = 1'b0;
      #1;
      check("arst_busy",     32'(hif.busy),      0);
      check("arst_gen_done", 32'(hif.gen_done),  0);
      check("arst_count",    32'(hif.gen_count), 0);
      check("arst_still",    32'(hif.still),     0);
      check("arst_rd_data",  32'(hif.rd_data),   0);
      hif.run = 1'b0;
      tick(2);
      Reset_n = 1'b1;
      tick(2);
      read_row(5, 16'h0000, "arst_row5");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
